// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: field map, packet types and flit packing.
// Used by the packet injector and the mesh router.
package noc_pkg;

   localparam int ADDR_MSB = 12;
   localparam int TYPE_MSB = 10;
   localparam int PAY_MSB  = 8;
   localparam int EOP_BIT  = 0;

   typedef enum logic [1:0] {
      PKT_REQ  = 2'b00,
      PKT_RESP = 2'b01,
      PKT_DATA = 2'b10,
      PKT_RSVD = 2'b11
   } pkt_type_e;

   typedef struct packed {
      logic [1:0] addr;
      pkt_type_e  typ;
      logic [7:0] payload;
      logic       eop;
   } flit_t;

   function automatic flit_t pack_flit(
      input logic [1:0] addr,
      input pkt_type_e  typ,
      input logic [7:0] pay,
      input logic       eop
   );
      flit_t f;
      f.addr    = addr;
      f.typ     = typ;
      f.payload = pay;
      f.eop     = eop;
      return f;
   endfunction

endpackage

// File: rtl/noc_packet_injector_if.sv
// Command, payload and flit handshake bundle of the packet injector.
// master = traffic source / flit sink side, slave = injector.
interface noc_packet_injector_if #(
   parameter int LenWidth  = 3,
   parameter int DataWidth = 13
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_addr;
   logic [1:0]           cmd_type;
   logic [LenWidth-1:0]  cmd_len;
   logic                 pay_valid;
   logic                 pay_ready;
   logic [7:0]           pay_data;
   logic                 flit_valid;
   logic [DataWidth-1:0] flit_data;
   logic                 flit_ready;

   modport master (
      output cmd_valid, cmd_addr, cmd_type, cmd_len,
      output pay_valid, pay_data, flit_ready,
      input  cmd_ready, pay_ready, flit_valid, flit_data
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_type, cmd_len,
      input  pay_valid, pay_data, flit_ready,
      output cmd_ready, pay_ready, flit_valid, flit_data
   );
endinterface

// File: rtl/noc_packet_injector.sv
// Source-side NoC transmitter: turns a packet command plus a byte
// stream into 13-bit flits, eop on the last flit of each packet.
module noc_packet_injector
   import noc_pkg::*;
#(
   parameter int DataWidth = 13,
   parameter int LenWidth  = 3,
   parameter int CntWidth  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   noc_packet_injector_if.slave bus,
   output logic                busy,
   output logic                pkt_done,
   output logic                err_reserved,
   output logic [CntWidth-1:0] flit_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          r_addr;
   pkt_type_e           r_type;
   logic [LenWidth-1:0] r_rem;
   flit_t               r_flit;
   logic                r_fv;
   logic                r_done;
   logic                r_err;
   logic [CntWidth-1:0] r_cnt;

   logic                w_cmd_acc;
   logic                w_pay_acc;
   logic                w_flit_acc;
   logic                w_eop;
   logic                w_last;
   flit_t               w_next;
   logic [LenWidth-1:0] w_rem_nxt;

   assign w_eop      = r_flit[EOP_BIT];
   assign w_last     = (r_rem == '0);
   assign w_cmd_acc  = bus.cmd_valid && bus.cmd_ready;
   assign w_pay_acc  = bus.pay_valid && bus.pay_ready;
   assign w_flit_acc = r_fv && bus.flit_ready;
   // r_rem counts flits still to load after the next one; it stops at 0
   assign w_rem_nxt  = w_last ? r_rem : r_rem - LenWidth'(1);
   assign w_next     = pack_flit(r_addr, r_type, bus.pay_data, w_last);

   assign bus.cmd_ready  = (r_state == S_IDLE);
   assign bus.pay_ready  = (r_state == S_LOAD) ||
                           ((r_state == S_SEND) && bus.flit_ready && !w_eop);
   assign bus.flit_valid = r_fv;
   assign bus.flit_data  = r_flit;
   assign busy           = (r_state != S_IDLE);
   assign pkt_done       = r_done;
   assign err_reserved   = r_err;
   assign flit_count     = r_cnt;

   // packet FSM, flit register, status pulses and accepted-flit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_type  <= PKT_REQ;
         r_rem   <= '0;
         r_flit  <= '0;
         r_fv    <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_flit_acc) r_cnt <= r_cnt + CntWidth'(1);
         unique case (1'b1)
            (r_state == S_IDLE): begin
               if (w_cmd_acc) begin
                  if (pkt_type_e'(bus.cmd_type) == PKT_RSVD) begin
                     r_err <= 1'b1;
                  end else begin
                     r_addr  <= bus.cmd_addr;
                     r_type  <= pkt_type_e'(bus.cmd_type);
                     r_rem   <= bus.cmd_len;
                     r_state <= S_LOAD;
                  end
               end
            end
            (r_state == S_LOAD): begin
               if (w_pay_acc) begin
                  r_flit  <= w_next;
                  r_rem   <= w_rem_nxt;
                  r_fv    <= 1'b1;
                  r_state <= S_SEND;
               end
            end
            (r_state == S_SEND): begin
               if (w_flit_acc) begin
                  if (w_eop) begin
                     r_done  <= 1'b1;
                     r_fv    <= 1'b0;
                     r_state <= S_IDLE;
                  end else if (w_pay_acc) begin
                     r_flit <= w_next;
                     r_rem  <= w_rem_nxt;
                  end else begin
                     r_fv    <= 1'b0;
                     r_state <= S_LOAD;
                  end
               end
            end
            default: begin
               r_fv    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
